matmul_4x4_sequencer: RTL and testbench
=======================================

Name: matmul_4x4_sequencer

Overview:
Controller that sequences a full 4x4 matrix product C = A x B using one shared multiply-accumulate stage.
- Reads A and B elements from the IP's operand register banks (1-cycle read latency).
- Accumulates the 4 products per output element.
- Writes the 16 results into the C bank.
- Reports busy/done/irq to the AXI4-Lite control/status registers of matrix_4x4_multiplier.

Parameters:
DATA_W, 8, width of one signed two's-complement A/B element
ACC_W, 2*DATA_W+2, width of each C element; exact, cannot overflow for 4 terms

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
start  in  1  one-cycle request from control register; sampled only in IDLE
abort  in  1  terminate current run
done_clr  in  1  clear sticky done
busy  out  1  high whenever state != IDLE
done  out  1  sticky completion flag
irq  out  1  one-cycle completion pulse
rd_en  out  1  operand read strobe
a_rd_idx  out  4  A index {row,k}
b_rd_idx  out  4  B index {k,col}
a_rd_data  in  DATA_W  A element, valid cycle after rd_en
b_rd_data  in  DATA_W  B element, valid cycle after rd_en
c_wr_en  out  1  result write strobe
c_wr_idx  out  4  C index {row,col}
c_wr_data  out  ACC_W  result, sign-extended sum of products

Behaviour:
- Interface fixed: one clock ACLK; reset ARESETN is asynchronous, active-low.
- While ARESETN=0, all outputs are 0; state=IDLE; counters and pipeline valids are 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when start=1. Clears done and loads counter n=0.
  - RUN: rd_en=1. n (6 bit) = {row[1:0], col[1:0], k[1:0]}. a_rd_idx={row,k}, b_rd_idx={k,col}. n increments every cycle. At n=63 -> DRAIN.
  - DRAIN: rd_en=0. Waits until the stage-1 valid and the write stage are empty, then -> IDLE. In the transition cycle: done<=1, irq=1 for exactly one cycle.
- Stage 1 (cycle after each read), driven by rd_en delayed one cycle with row/col/k.
  - prod = signed(a_rd_data) * signed(b_rd_data).
  - sum = (k==0 ? 0 : acc) + sign-extended prod.
  - acc <= sum.
  - When k==3, the next edge registers c_wr_en=1, c_wr_idx={row,col}, c_wr_data=sum.
- c_wr_en is otherwise 0. Exactly 16 writes per completed run, in index order 0..15, spaced 4 cycles apart.
- Timing, with start high in cycle S:
  - RUN occupies S+1..S+64.
  - First c_wr_en in cycle S+6; last in S+66.
  - done=1 and irq=1 in S+67; busy=0 from S+67.
- start while busy: ignored; it neither restarts nor queues.
- abort in RUN/DRAIN: next cycle state=IDLE, rd_en=0.
  - Pipeline valids are cleared; no further c_wr_en, including one pending for that edge.
  - done stays 0; no irq.
  - abort in IDLE has no effect.
- done_clr: done<=0. If start and done_clr coincide in IDLE, the run starts and done=0.
- abort and start in the same IDLE cycle: start wins; abort is ignored because it is only sampled when busy.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0; no partial completion indication.

Decomposition:
- Package matmul_pkg:
  - MAT_DIM=4, IDX_W=4, CNT_W=6.
  - State enum seq_state_t {IDLE, RUN, DRAIN}.
  - Function acc_width(data_w) = 2*data_w+2.
- Sub-module matmul_mac: stage-1 signed multiply, accumulator register, k==0 clear, and registered write outputs, with a flush input driven by abort.
- FSM and counter stay in matmul_4x4_sequencer.

Test Plan:
1. A = identity, B = 1..16 row-major, start at S.
   - Required: c_wr_en at S+6, S+10, ... S+66, indices 0..15.
   - c_wr_data equals B.
   - done and irq at S+67.
   - busy high S+1..S+66.
2. A=B all -128 (DATA_W=8).
   - Required: every c_wr_data = 18'h10000 (65536), no wrap.
   - A=all 127, B=all -128: every c_wr_data = -65024.
3. Second start pulse at S+10 while busy.
   - Required: exactly 16 writes, done at S+67, no second run.
4. abort at S+30.
   - Required: busy=0 and rd_en=0 from S+31; zero c_wr_en from S+31; done=0; irq never pulses.
5. ARESETN dropped asynchronously mid-cycle at S+20.
   - Required: all outputs 0 immediately.
   - After release, a new start gives the full correct 16-write pass.
6. done sticky check.
   - done remains 1 for 100 idle cycles; done_clr -> 0 next cycle.
   - start+done_clr together -> done 0 until the new completion.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the 4x4 matrix-multiply sequencer.
package matmul_pkg;

  localparam int MAT_DIM = 4;  // rows/cols/terms per output element
  localparam int IDX_W   = 4;  // {row,col} / {row,k} / {k,col} index width
  localparam int CNT_W   = 6;  // sequence counter {row,col,k}

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Width that holds the exact sum of MAT_DIM signed data_w x data_w products.
  function automatic int acc_width(input int data_w);
    return 2 * data_w + 2;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Stage-1 multiply-accumulate: one signed product per cycle, summed over k,
// with a registered write port for each completed C element.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = acc_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              flush,
  input  logic [CNT_W-1:0]  rd_cnt,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              stage_busy,
  output logic              c_wr_en,
  output logic [IDX_W-1:0]  c_wr_idx,
  output logic [ACC_W-1:0]  c_wr_data
);

  logic                       s1_valid_reg;
  logic [CNT_W-1:0]           s1_cnt_reg;
  logic signed [ACC_W-1:0]    acc_reg;
  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_base;
  logic signed [ACC_W-1:0]    sum_next;
  logic                       last_k;
  logic                       wr_en_reg;
  logic [IDX_W-1:0]           wr_idx_reg;
  logic [ACC_W-1:0]           wr_data_reg;

  // Operands are widened before multiplying so the product is exact.
  assign a_ext    = {{DATA_W{a_data[DATA_W-1]}}, a_data};
  assign b_ext    = {{DATA_W{b_data[DATA_W-1]}}, b_data};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // k==0 starts a fresh element, so the old accumulator is ignored there.
  assign acc_base = (s1_cnt_reg[1:0] == 2'd0) ? '0 : acc_reg;
  assign sum_next = acc_base + prod_ext;
  assign last_k   = (s1_cnt_reg[1:0] == 2'(MAT_DIM - 1));

  assign stage_busy = s1_valid_reg;
  assign c_wr_en    = wr_en_reg;
  assign c_wr_idx   = wr_idx_reg;
  assign c_wr_data  = wr_data_reg;

  // Track read data one cycle behind the request, accumulate, and register writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_cnt_reg   <= '0;
      acc_reg      <= '0;
      wr_en_reg    <= 1'b0;
      wr_idx_reg   <= '0;
      wr_data_reg  <= '0;
    end else begin
      s1_valid_reg <= rd_en & ~flush;
      s1_cnt_reg   <= rd_cnt;
      if (s1_valid_reg) begin
        acc_reg <= sum_next;
      end
      // A flush also kills a write that would otherwise land on this edge.
      wr_en_reg <= s1_valid_reg & last_k & ~flush;
      if (s1_valid_reg && last_k && !flush) begin
        wr_idx_reg  <= {s1_cnt_reg[5:4], s1_cnt_reg[3:2]};
        wr_data_reg <= sum_next;
      end
    end
  end

endmodule

// File: rtl/matmul_4x4_sequencer.sv
// Sequences C = A x B over 64 read cycles through a single MAC stage and
// reports busy / sticky done / one-cycle irq.
module matmul_4x4_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = acc_width(DATA_W)
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic              abort,
  input  logic              done_clr,
  output logic              busy,
  output logic              done,
  output logic              irq,
  output logic              rd_en,
  output logic [IDX_W-1:0]  a_rd_idx,
  output logic [IDX_W-1:0]  b_rd_idx,
  input  logic [DATA_W-1:0] a_rd_data,
  input  logic [DATA_W-1:0] b_rd_data,
  output logic              c_wr_en,
  output logic [IDX_W-1:0]  c_wr_idx,
  output logic [ACC_W-1:0]  c_wr_data
);

  seq_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             rd_en_reg;
  logic             done_reg;
  logic             irq_reg;
  logic             flush;
  logic             stage_busy;

  // abort only matters while a run is in flight.
  assign flush = abort & busy_reg;

  // cnt_reg = {row, col, k}
  assign a_rd_idx = {cnt_reg[5:4], cnt_reg[1:0]};
  assign b_rd_idx = {cnt_reg[1:0], cnt_reg[3:2]};

  assign busy  = busy_reg;
  assign rd_en = rd_en_reg;
  assign done  = done_reg;
  assign irq   = irq_reg;

  // Control FSM: IDLE -> RUN (64 reads) -> DRAIN (wait for MAC) -> IDLE.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      rd_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      irq_reg <= 1'b0;
      if (done_clr) begin
        done_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            rd_en_reg <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            rd_en_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == '1) begin
              state_reg <= DRAIN;
              rd_en_reg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (!stage_busy) begin
            // Last product is in the write register; completion is reported now.
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            irq_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          rd_en_reg <= 1'b0;
        end
      endcase
    end
  end

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .rd_en      (rd_en_reg),
    .flush      (flush),
    .rd_cnt     (cnt_reg),
    .a_data     (a_rd_data),
    .b_data     (b_rd_data),
    .stage_busy (stage_busy),
    .c_wr_en    (c_wr_en),
    .c_wr_idx   (c_wr_idx),
    .c_wr_data  (c_wr_data)
  );

endmodule

// File: tb/tb_matmul_4x4_sequencer.sv
// Bench for matmul_4x4_sequencer: a cycle-timeline model of one run plus a
// plain-arithmetic matrix product, checked every cycle, plus directed checks.
module tb_matmul_4x4_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        done_clr = 1'b0;
  logic        busy, done, irq, rd_en, c_wr_en;
  logic [3:0]  a_rd_idx, b_rd_idx, c_wr_idx;
  logic [7:0]  a_rd_data = 8'd0;
  logic [7:0]  b_rd_data = 8'd0;
  logic [17:0] c_wr_data;

  logic signed [7:0] mem_a [16];
  logic signed [7:0] mem_b [16];
  int c_model [16];

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;
  int wr_count = 0;

  // model state
  bit have_run = 0;
  bit aborted = 0;
  bit done_m = 0;
  bit prev_clr = 0;
  int s_cyc = 0;
  int abort_cyc = 0;

  matmul_4x4_sequencer #(.DATA_W(8), .ACC_W(18)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .start     (start),
    .abort     (abort),
    .done_clr  (done_clr),
    .busy      (busy),
    .done      (done),
    .irq       (irq),
    .rd_en     (rd_en),
    .a_rd_idx  (a_rd_idx),
    .b_rd_idx  (b_rd_idx),
    .a_rd_data (a_rd_data),
    .b_rd_data (b_rd_data),
    .c_wr_en   (c_wr_en),
    .c_wr_idx  (c_wr_idx),
    .c_wr_data (c_wr_data)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Operand banks: one-cycle read latency.
  always @(posedge ACLK) begin
    if (rd_en) begin
      a_rd_data <= mem_a[a_rd_idx];
      b_rd_data <= mem_b[b_rd_idx];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic compute_model();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(mem_a[r*4+k]) * int'(mem_b[k*4+c]);
        c_model[r*4+c] = s;
      end
    end
  endtask

  // Per-cycle compare against the timeline of the current run.
  always @(negedge ACLK) begin : cmp
    int  rel, n, wi;
    bit  live, exp_busy, exp_rd, exp_wr, exp_irq;
    logic [17:0] exp_data;
    if (!ARESETN) begin
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_c_wr_en", 32'(c_wr_en), 32'd0);
      check("rst_c_wr_data", 32'(c_wr_data), 32'd0);
      have_run = 0;
      aborted  = 0;
      done_m   = 0;
      prev_clr = 0;
    end else begin
      rel  = cyc - s_cyc;
      live = have_run && !(aborted && cyc > abort_cyc);
      if (prev_clr) done_m = 0;
      if (live && rel == 1) done_m = 0;
      if (live && rel == 67) done_m = 1;
      exp_busy = live && rel >= 1 && rel <= 66;
      exp_rd   = live && rel >= 1 && rel <= 64;
      exp_wr   = live && rel >= 6 && rel <= 66 && ((rel - 6) % 4 == 0);
      exp_irq  = live && rel == 67;
      check("busy", 32'(busy), 32'(exp_busy));
      check("rd_en", 32'(rd_en), 32'(exp_rd));
      check("c_wr_en", 32'(c_wr_en), 32'(exp_wr));
      check("irq", 32'(irq), 32'(exp_irq));
      check("done", 32'(done), 32'(done_m));
      if (exp_rd) begin
        n = rel - 1;
        check("a_rd_idx", 32'(a_rd_idx), 32'((n / 16) * 4 + n % 4));
        check("b_rd_idx", 32'(b_rd_idx), 32'((n % 4) * 4 + (n / 4) % 4));
      end
      if (exp_wr) begin
        wi = (rel - 6) / 4;
        exp_data = 18'(c_model[wi]);
        check("c_wr_idx", 32'(c_wr_idx), 32'(wi));
        check("c_wr_data", 32'(c_wr_data), 32'(exp_data));
      end
      if (c_wr_en) wr_count++;
      if (abort && exp_busy) begin
        aborted   = 1;
        abort_cyc = cyc;
      end
      if (start && !exp_busy) begin
        have_run = 1;
        aborted  = 0;
        s_cyc    = cyc;
      end
      prev_clr = done_clr;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic run_full(input string name);
    int s;
    wr_count = 0;
    pulse_start(s);
    repeat (66) tick();
    check({name, "_done_at_67"}, 32'(done), 32'd1);
    check({name, "_irq_at_67"}, 32'(irq), 32'd1);
    check({name, "_busy_at_67"}, 32'(busy), 32'd0);
    tick();
    check({name, "_irq_one_cycle"}, 32'(irq), 32'd0);
    check({name, "_write_count"}, 32'(wr_count), 32'd16);
    $display("[TB] run %s started cycle %0d writes %0d done %0d", name, s, wr_count, done);
  endtask

  task automatic load_identity();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = (i / 4 == i % 4) ? 8'sd1 : 8'sd0;
      mem_b[i] = 8'(i + 1);
    end
    compute_model();
  endtask

  initial begin
    int s;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'sd0;
      mem_b[i] = 8'sd0;
      c_model[i] = 0;
    end

    repeat (3) tick();
    ARESETN = 1'b1;
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_done", 32'(done), 32'd0);
    tick();

    // 1: identity x (1..16) reproduces B
    load_identity();
    check("pin_ident_c0", 32'(c_model[0]), 32'd1);
    check("pin_ident_c5", 32'(c_model[5]), 32'd6);
    check("pin_ident_c15", 32'(c_model[15]), 32'd16);
    run_full("identity");
    repeat (3) tick();

    // 2: extreme operands, no wrap
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = -8'sd128;
      mem_b[i] = -8'sd128;
    end
    compute_model();
    check("pin_neg128_sq", 32'(c_model[7]), 32'd65536);
    run_full("neg128");
    for (int i = 0; i < 16; i++) mem_a[i] = 8'sd127;
    compute_model();
    check("pin_127_x_neg128", 32'(c_model[3]), 32'(-65024));
    run_full("127xneg128");
    repeat (2) tick();

    // 3: second start while busy is ignored
    load_identity();
    wr_count = 0;
    pulse_start(s);
    repeat (9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (56) tick();
    check("restart_done_at_67", 32'(done), 32'd1);
    check("restart_irq_at_67", 32'(irq), 32'd1);
    repeat (80) tick();
    check("restart_write_count", 32'(wr_count), 32'd16);
    check("restart_busy_after", 32'(busy), 32'd0);
    $display("[TB] run ignored-restart started cycle %0d writes %0d", s, wr_count);

    // 4: abort at S+30
    wr_count = 0;
    pulse_start(s);
    repeat (29) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort30_busy", 32'(busy), 32'd0);
    check("abort30_rd_en", 32'(rd_en), 32'd0);
    repeat (40) tick();
    check("abort30_write_count", 32'(wr_count), 32'd7);
    check("abort30_done", 32'(done), 32'd0);
    $display("[TB] run abort@30 started cycle %0d writes %0d", s, wr_count);

    // 4b: abort at S+33 suppresses the write due on that edge
    wr_count = 0;
    pulse_start(s);
    repeat (32) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort33_c_wr_en", 32'(c_wr_en), 32'd0);
    repeat (40) tick();
    check("abort33_write_count", 32'(wr_count), 32'd7);
    check("abort33_done", 32'(done), 32'd0);
    $display("[TB] run abort@33 started cycle %0d writes %0d", s, wr_count);

    // 5: asynchronous reset mid-run
    pulse_start(s);
    repeat (19) tick();
    #2;
    ARESETN = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_rd_en", 32'(rd_en), 32'd0);
    check("areset_c_wr_en", 32'(c_wr_en), 32'd0);
    check("areset_c_wr_idx", 32'(c_wr_idx), 32'd0);
    check("areset_c_wr_data", 32'(c_wr_data), 32'd0);
    check("areset_done", 32'(done), 32'd0);
    check("areset_irq", 32'(irq), 32'd0);
    tick();
    tick();
    ARESETN = 1'b1;
    tick();
    $display("[TB] reset applied mid-run started cycle %0d", s);
    run_full("after_reset");

    // 6: sticky done, done_clr, start+done_clr
    repeat (100) tick();
    check("done_sticky_100", 32'(done), 32'd1);
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    check("done_clr_next", 32'(done), 32'd0);
    run_full("before_combo");
    start = 1'b1;
    done_clr = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    done_clr = 1'b0;
    check("combo_done_s1", 32'(done), 32'd0);
    check("combo_busy_s1", 32'(busy), 32'd1);
    repeat (65) tick();
    check("combo_done_s66", 32'(done), 32'd0);
    tick();
    check("combo_done_s67", 32'(done), 32'd1);
    $display("[TB] run start+done_clr started cycle %0d done %0d", s, done);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
